// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: per-stage control bundles, their widths,
// field offsets and the all-zero NOP bundle used for bubbles and flushes.
package pipe_pkg;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [4:0] rd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_to_reg;
    logic [4:0] rd;
  } mem_wb_ctrl_t;

  localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  localparam int unsigned ID_EX_RD_LSB         = 0;
  localparam int unsigned ID_EX_ALU_OP_LSB     = 5;
  localparam int unsigned ID_EX_ALU_SRC_BIT    = 9;
  localparam int unsigned ID_EX_JUMP_BIT       = 10;
  localparam int unsigned ID_EX_BRANCH_BIT     = 11;
  localparam int unsigned ID_EX_MEM_WRITE_BIT  = 12;
  localparam int unsigned ID_EX_MEM_READ_BIT   = 13;
  localparam int unsigned ID_EX_MEM_TO_REG_BIT = 14;
  localparam int unsigned ID_EX_REG_WR_BIT     = 15;

  localparam int unsigned EX_MEM_RD_LSB         = 0;
  localparam int unsigned EX_MEM_MEM_SIZE_LSB   = 5;
  localparam int unsigned EX_MEM_MEM_WRITE_BIT  = 7;
  localparam int unsigned EX_MEM_MEM_READ_BIT   = 8;
  localparam int unsigned EX_MEM_MEM_TO_REG_BIT = 9;
  localparam int unsigned EX_MEM_REG_WR_BIT     = 10;

  localparam int unsigned MEM_WB_RD_LSB         = 0;
  localparam int unsigned MEM_WB_MEM_TO_REG_BIT = 5;
  localparam int unsigned MEM_WB_REG_WR_BIT     = 6;

  localparam id_ex_ctrl_t  ID_EX_NOP  = '0;
  localparam ex_mem_ctrl_t EX_MEM_NOP = '0;
  localparam mem_wb_ctrl_t MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One buffer slot: valid flag plus ctrl/data payload. Clear beats load beats unload;
// payload flops only change on load or clear.
module pipe_skid_entry #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_in;
      data_d  = data_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush to NOP and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
  logic [DATA_W-1:0] m_data, s_data, m_data_in;
  logic              in_fire, out_fire;
  logic              m_load, m_unload, m_from_s, s_load, s_unload;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // With a skid entry, in_ready is simply the inverted S valid flop.
  assign in_ready  = (SKID != 0) ? !s_valid : (!m_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;

  always_comb begin
    m_load   = 1'b0;
    m_unload = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_unload = 1'b0;
    if (SKID != 0) begin
      if (!m_valid) begin
        m_load = in_fire;
      end else if (out_ready) begin
        if (s_valid) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_unload = 1'b1;
        end else if (in_fire) begin
          m_load = 1'b1;
        end else begin
          m_unload = 1'b1;
        end
      end else begin
        s_load = in_fire;
      end
    end else begin
      m_load   = in_fire;
      m_unload = out_fire & !in_fire;
    end
  end

  assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
  assign m_data_in = m_from_s ? s_data : in_data;

  pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (m_load),
    .unload  (m_unload),
    .ctrl_in (m_ctrl_in),
    .data_in (m_data_in),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (s_load),
      .unload  (s_unload),
      .ctrl_in (in_ctrl),
      .data_in (in_data),
      .valid   (s_valid),
      .ctrl    (s_ctrl),
      .data    (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_ctrl  = '0;
    assign s_data  = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : NOP_CTRL;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in lockstep and compared
// every cycle against a FIFO-queue reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [15:0]  ctrl;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [15:0]  in_ctrl = '0;
  logic [127:0] in_data = '0;

  logic         d0_in_ready, d1_in_ready, d2_in_ready;
  logic         d0_out_valid, d1_out_valid, d2_out_valid;
  logic [15:0]  d0_out_ctrl, d1_out_ctrl, d2_out_ctrl;
  logic [127:0] d0_out_data, d1_out_data, d2_out_data;
  logic [1:0]   d0_occ, d1_occ, d2_occ;
  logic [15:0]  d0_stall, d2_stall;
  logic [2:0]   d1_stall;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_ctrl(d0_out_ctrl), .out_data(d0_out_data), .occupancy(d0_occ), .stall_cnt(d0_stall));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_ctrl(d1_out_ctrl), .out_data(d1_out_data), .occupancy(d1_occ), .stall_cnt(d1_stall));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(0), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_ctrl(d2_out_ctrl), .out_data(d2_out_data), .occupancy(d2_occ), .stall_cnt(d2_stall));

  logic         o_rdy [3];
  logic         o_vld [3];
  logic [15:0]  o_ctrl [3];
  logic [127:0] o_data [3];
  logic [1:0]   o_occ [3];
  logic [15:0]  o_stall [3];

  assign o_rdy[0] = d0_in_ready;   assign o_rdy[1] = d1_in_ready;   assign o_rdy[2] = d2_in_ready;
  assign o_vld[0] = d0_out_valid;  assign o_vld[1] = d1_out_valid;  assign o_vld[2] = d2_out_valid;
  assign o_ctrl[0] = d0_out_ctrl;  assign o_ctrl[1] = d1_out_ctrl;  assign o_ctrl[2] = d2_out_ctrl;
  assign o_data[0] = d0_out_data;  assign o_data[1] = d1_out_data;  assign o_data[2] = d2_out_data;
  assign o_occ[0] = d0_occ;        assign o_occ[1] = d1_occ;        assign o_occ[2] = d2_occ;
  assign o_stall[0] = d0_stall;    assign o_stall[1] = {13'b0, d1_stall}; assign o_stall[2] = d2_stall;

  // Reference model: per configuration a FIFO of accepted beats, the last beat that
  // left the stage, and the stall count.
  beat_t        mq [3][$];
  logic [127:0] m_last [3];
  int unsigned  m_stall [3];
  int unsigned  m_cap [3]   = '{2, 2, 1};
  int unsigned  m_smax [3]  = '{65535, 7, 65535};
  bit           m_skid [3]  = '{1'b1, 1'b1, 1'b0};
  bit           fire_in [3];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  function automatic bit exp_in_ready(input int d);
    if (m_skid[d]) return mq[d].size() < 2;
    return (mq[d].size() == 0) || out_ready;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      bit           v;
      logic [15:0]  ec;
      logic [127:0] ed;
      v  = mq[d].size() > 0;
      ec = v ? mq[d][0].ctrl : 16'h0;
      ed = v ? mq[d][0].data : m_last[d];
      chk("in_ready",  d, {127'b0, o_rdy[d]}, {127'b0, exp_in_ready(d)});
      chk("out_valid", d, {127'b0, o_vld[d]}, {127'b0, v});
      chk("out_ctrl",  d, {112'b0, o_ctrl[d]}, {112'b0, ec});
      chk("out_data",  d, o_data[d], ed);
      chk("occupancy", d, {126'b0, o_occ[d]}, 128'(mq[d].size()));
      chk("stall_cnt", d, {112'b0, o_stall[d]}, 128'(m_stall[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      m_last[d]  = '0;
      m_stall[d] = 0;
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model past the rising edge.
  task automatic step();
    bit fo [3];
    @(negedge clk);
    check_all();
    for (int d = 0; d < 3; d++) begin
      fire_in[d] = in_valid && exp_in_ready(d);
      fo[d]      = (mq[d].size() > 0) && out_ready;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (mq[d].size() > 0 && !out_ready && !flush && m_stall[d] < m_smax[d])
        m_stall[d]++;
      if (flush) begin
        mq[d].delete();
        m_last[d] = '0;
      end else begin
        if (fo[d]) begin
          beat_t b;
          b = mq[d].pop_front();
          m_last[d] = b.data;
        end
        if (fire_in[d]) mq[d].push_back('{ctrl: in_ctrl, data: in_data});
        if (mq[d].size() > m_cap[d]) begin
          n_chk++;
          n_fail++;
          $error("FAIL model_overflow dut%0d: observed %0d expected <= %0d", d, mq[d].size(), m_cap[d]);
        end
      end
    end
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_vld", 0, {127'b0, d0_out_valid}, 128'd0);
    chk("rst_occ", 0, {126'b0, d0_occ}, 128'd0);
    chk("rst_rdy", 0, {127'b0, d0_in_ready}, 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int idx;
    #1;
    async_reset();

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 16'($urandom);
      in_data  = 128'(i);
      step();
      chk("stream_occ", 0, {126'b0, d0_occ}, 128'd1);
      chk("stream_dat", 0, d0_out_data, 128'(i));
    end
    in_valid = 1'b0;
    step();

    // Back-pressure: beat 2 lands in the skid entry, beat 3 waits upstream.
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc == 0) || (cyc >= 5);
      in_valid  = idx < 3;
      in_ctrl   = 16'($urandom) | 16'h1;
      in_data   = 128'(idx + 1);
      step();
      if (fire_in[0]) idx++;
      if (cyc == 1) begin
        chk("bp_occ", 0, {126'b0, d0_occ}, 128'd2);
        chk("bp_rdy", 0, {127'b0, d0_in_ready}, 128'd0);
      end
    end

    // Flush with both entries full; the same-cycle 0xAA beat must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h00F1; in_data = 128'h11; step();
    in_ctrl   = 16'h00F2; in_data = 128'h22; step();
    chk("pre_flush_occ", 0, {126'b0, d0_occ}, 128'd2);
    flush = 1'b1;
    in_ctrl = 16'h00F3; in_data = 128'hAA; step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_vld", 0, {127'b0, d0_out_valid}, 128'd0);
    chk("flush_ctrl", 0, {112'b0, d0_out_ctrl}, 128'd0);
    chk("flush_data", 0, d0_out_data, 128'd0);
    chk("flush_occ", 0, {126'b0, d0_occ}, 128'd0);
    out_ready = 1'b1;
    step();
    step();

    // Stall counter: 5 stalled cycles, then saturation of the 3-bit counter.
    async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0042; in_data = 128'h5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stall5", 0, {112'b0, d0_stall}, 128'd5);
    for (int i = 0; i < 5; i++) step();
    chk("stall_sat", 1, {125'b0, d1_stall}, 128'd7);
    chk("stall10", 0, {112'b0, d0_stall}, 128'd10);

    // SKID=0: combinational ready follows out_ready while full.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk("s0_rdy_hi", 2, {127'b0, d2_in_ready}, 128'd1);
    out_ready = 1'b0;
    #1;
    chk("s0_rdy_lo", 2, {127'b0, d2_in_ready}, 128'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 128'(100 + i);
      step();
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 6;
      flush     = ($urandom % 20) == 0;
      in_ctrl   = 16'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    flush = 1'b0;

    // Async reset between edges while the skid entry is occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 128'(200 + i);
      step();
    end
    chk("pre_rst_occ", 0, {126'b0, d0_occ}, 128'd2);
    #2;
    async_reset();
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
